// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multi-cycle multiply/divide sequencer owning the HI/LO pair.
//
// An accepted mult/multu/div/divu computes its full 64-bit result at the
// accept edge into temp_hi/temp_lo. It then models the unit latency with a
// down-counter and copies the temp values into HI/LO only when the counter
// expires. mthi/mtlo write HI/LO directly in a single cycle. A flush cancels
// the in-flight operation. A divide by zero runs the full latency and pulses
// done, but it leaves HI/LO untouched.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    EX-stage request, sampled on rising clk
//   md_op    0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A, B     rs / rt operands
//   flush    cancels in-flight op, blocks a same-cycle start
//   busy     high while an operation is in flight
//   done     one-cycle pulse after a completed operation
//   hi_out   current HI
//   lo_out   current LO
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [31:0] hi_q, hi_nxt, lo_q, lo_nxt;
  logic [31:0] temp_hi, temp_hi_nxt, temp_lo, temp_lo_nxt;
  logic        div0_q, div0_nxt;
  logic        done_q, done_nxt;
  logic [63:0] res;

  // Full {HI, LO} result of an arithmetic op. A zero divisor returns zero;
  // the caller suppresses that commit.
  function automatic logic [63:0] md_result(input logic [2:0]  op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa64, sb64, sprod;
    logic [63:0]        ua64, ub64;
    logic signed [31:0] sa, sb, sq, sr;
    md_result = '0;
    case (op)
      OP_MULT: begin
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sprod = sa64 * sb64;
        md_result = sprod;
      end
      OP_MULTU: begin
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        md_result = ua64 * ub64;
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          md_result = '0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // The quotient does not fit; the result wraps to the dividend.
          md_result = {32'd0, 32'h8000_0000};
        end else begin
          sa = a;
          sb = b;
          sq = sa / sb;
          sr = sa % sb;
          md_result = {sr, sq};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) md_result = '0;
        else            md_result = {a % b, a / b};
      end
      default: md_result = '0;
    endcase
  endfunction

  assign res = md_result(md_op, A, B);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi_q;
    lo_nxt      = lo_q;
    temp_hi_nxt = temp_hi;
    temp_lo_nxt = temp_lo;
    div0_nxt    = div0_q;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              temp_hi_nxt = res[63:32];
              temp_lo_nxt = res[31:0];
              cnt_nxt     = MULT_N;
              div0_nxt    = 1'b0;
              state_nxt   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              temp_hi_nxt = res[63:32];
              temp_lo_nxt = res[31:0];
              cnt_nxt     = DIV_N;
              div0_nxt    = (B == 32'd0);
              state_nxt   = RUN;
            end
            OP_MTHI: hi_nxt = A;
            OP_MTLO: lo_nxt = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Requests in RUN are ignored; flush wins over a same-edge commit.
        if (flush) begin
          state_nxt = IDLE;
          cnt_nxt   = 5'd0;
        end else begin
          cnt_nxt = cnt - 5'd1;
          if (cnt == 5'd1) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            if (!div0_q) begin
              hi_nxt = temp_hi;
              lo_nxt = temp_lo;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      hi_q    <= '0;
      lo_q    <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
      temp_hi <= temp_hi_nxt;
      temp_lo <= temp_lo_nxt;
      div0_q  <= div0_nxt;
      done_q  <= done_nxt;
    end
  end

  assign busy   = (state == RUN);
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int passed = 0;
  int total  = 0;
  int n;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
    .A(A), .B(B), .flush(flush), .busy(busy), .done(done),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a falling edge. Presents one request for one rising edge and
  // returns at the falling edge that follows it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
  endtask

  // Counts the busy falling edges starting at the current one (bounded).
  task automatic count_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    issue(op, a, b);
    count_busy(cycles);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1. mult -2 * 3
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, n);
    chk("mult_busy_cycles", 32'(n), 32'd5);
    chk("mult_done", 32'(done), 32'd1);
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFFA);
    @(negedge clk);
    chk("mult_done_pulse_end", 32'(done), 32'd0);

    // 2. multu, then signed div -7 / 2
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("multu_busy_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi_out, 32'hFFFF_FFFE);
    chk("multu_lo", lo_out, 32'h0000_0001);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_busy_cycles", 32'(n), 32'd10);
    chk("div_done", 32'(done), 32'd1);
    chk("div_lo", lo_out, 32'hFFFF_FFFD);
    chk("div_hi", hi_out, 32'hFFFF_FFFF);

    // 3. mthi/mtlo preload, divu by zero, div overflow
    issue(3'd5, 32'h1234, 32'd0);
    chk("mthi_hi", hi_out, 32'h1234);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(3'd6, 32'h5678, 32'd0);
    chk("mtlo_lo", lo_out, 32'h5678);
    chk("mtlo_done", 32'(done), 32'd0);
    run_op(3'd4, 32'd100, 32'd0, n);
    chk("div0_busy_cycles", 32'(n), 32'd10);
    chk("div0_done", 32'(done), 32'd1);
    chk("div0_hi_kept", hi_out, 32'h1234);
    chk("div0_lo_kept", lo_out, 32'h5678);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("divovf_lo", lo_out, 32'h8000_0000);
    chk("divovf_hi", hi_out, 32'd0);

    // 4. flush on the 4th busy cycle
    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_hi", hi_out, 32'd0);
    chk("flush_lo", lo_out, 32'h8000_0000);
    //    flush on the completion edge
    issue(3'd1, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    chk("flushc_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flushc_busy", 32'(busy), 32'd0);
    chk("flushc_done", 32'(done), 32'd0);
    chk("flushc_lo", lo_out, 32'h8000_0000);
    //    flush together with start in IDLE
    flush = 1'b1;
    issue(3'd6, 32'd5, 32'd0);
    flush = 1'b0;
    chk("flush_start_lo", lo_out, 32'h8000_0000);
    chk("flush_start_busy", 32'(busy), 32'd0);

    // 5. requests during busy are ignored
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    start = 1'b1; md_op = 3'd5; A = 32'hAA;
    @(negedge clk);
    md_op = 3'd2; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    count_busy(n);
    chk("coll_remaining_busy", 32'(n), 32'd2);
    chk("coll_hi", hi_out, 32'd1);
    chk("coll_lo", lo_out, 32'd0);
    //    back-to-back start on the first non-busy cycle
    run_op(3'd1, 32'd3, 32'd5, n);
    chk("b2b_busy_cycles", 32'(n), 32'd5);
    chk("b2b_lo", lo_out, 32'd15);
    chk("b2b_hi", hi_out, 32'd0);

    // 6. asynchronous reset in the middle of a divide
    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_hi", hi_out, 32'd0);
    chk("arst_lo", lo_out, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(3'd1, 32'd6, 32'd7, n);
    chk("post_rst_busy_cycles", 32'(n), 32'd5);
    chk("post_rst_lo", lo_out, 32'd42);
    chk("post_rst_hi", hi_out, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
